imm_encoder: RTL and testbench

Streaming encoder that converts 16-bit constants into the 8-bit immediate field (two 4-bit nibbles, bits 7:4 and 3:0) consumed by the processor's immediate sign-extension path. Constants that survive 8→16 sign extension unchanged are emitted as one SHORT beat. All other constants are split into a HI/LO beat pair that the downstream load sequence recombines exactly. The block sits between the constant source (loader/assembler path) and the instruction-field builder, with valid/ready handshakes on both sides.

---
 rtl/imm_pkg.sv | 20 ++
 rtl/imm_split.sv | 16 +
 rtl/imm_encoder.sv | 91 +++++++++
 tb/tb_imm_encoder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared widths, beat kinds and FSM states for the immediate encoder
package imm_pkg;

  localparam int DATA_W  = 16;
  localparam int FIELD_W = 8;
  localparam int NIB_W   = 4;
  localparam int CNT_W   = 8;

  localparam logic [1:0] KIND_SHORT = 2'b00;
  localparam logic [1:0] KIND_HI    = 2'b01;
  localparam logic [1:0] KIND_LO    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHORT = 2'd1,
    ST_HI    = 2'd2,
    ST_LO    = 2'd3
  } state_t;

endpackage

// File: rtl/imm_split.sv
// rtl/imm_split.sv - combinational fit test and HI/LO field split of a 16-bit constant
module imm_split
  import imm_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  output logic               fits,
  output logic [FIELD_W-1:0] hi_field,
  output logic [FIELD_W-1:0] lo_field
);

  assign fits     = (data[15:8] == {8{data[7]}});
  assign lo_field = data[7:0];
  // LO is sign-extended downstream, so a negative LO borrows one from HI; add it back here.
  assign hi_field = data[15:8] + {7'd0, data[7]};

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - streams 16-bit constants out as SHORT or HI/LO 8-bit immediate beats
module imm_encoder
  import imm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NIB_W-1:0]  instr7_4,
  output logic [NIB_W-1:0]  instr3_0,
  output logic [1:0]        out_kind,
  output logic              out_last,
  output logic [CNT_W-1:0]  short_cnt,
  output logic [CNT_W-1:0]  long_cnt
);

  state_t             state;
  logic [FIELD_W-1:0] field_q;
  logic [FIELD_W-1:0] lo_hold;
  logic               fits;
  logic [FIELD_W-1:0] hi_field;
  logic [FIELD_W-1:0] lo_field;
  logic               accept;

  imm_split u_split (
    .data     (in_data),
    .fits     (fits),
    .hi_field (hi_field),
    .lo_field (lo_field)
  );

  assign in_ready = (state == ST_IDLE) ||
                    (((state == ST_SHORT) || (state == ST_LO)) && out_ready);
  assign accept   = in_valid && in_ready;
  assign instr7_4 = field_q[7:4];
  assign instr3_0 = field_q[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      field_q   <= '0;
      lo_hold   <= '0;
      out_valid <= 1'b0;
      out_kind  <= KIND_SHORT;
      out_last  <= 1'b0;
      short_cnt <= '0;
      long_cnt  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        if (state == ST_SHORT) short_cnt <= short_cnt + 8'd1;
        if (state == ST_LO)    long_cnt  <= long_cnt + 8'd1;
      end

      case (state)
        ST_HI: begin
          // HI never accepts input, so its LO always follows directly.
          if (out_ready) begin
            state    <= ST_LO;
            field_q  <= lo_hold;
            out_kind <= KIND_LO;
            out_last <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            out_valid <= 1'b1;
            lo_hold   <= lo_field;
            if (fits) begin
              state    <= ST_SHORT;
              field_q  <= lo_field;
              out_kind <= KIND_SHORT;
              out_last <= 1'b1;
            end else begin
              state    <= ST_HI;
              field_q  <= hi_field;
              out_kind <= KIND_HI;
              out_last <= 1'b0;
            end
          end else if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder with directed table and random scoreboard
module tb_imm_encoder;
  import imm_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  instr7_4;
  logic [3:0]  instr3_0;
  logic [1:0]  out_kind;
  logic        out_last;
  logic [7:0]  short_cnt;
  logic [7:0]  long_cnt;

  imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr7_4  (instr7_4),
    .instr3_0  (instr3_0),
    .out_kind  (out_kind),
    .out_last  (out_last),
    .short_cnt (short_cnt),
    .long_cnt  (long_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit ref_fits(input logic [15:0] d);
    int s;
    s = int'($signed(d));
    return (s >= -128) && (s <= 127);
  endfunction

  // Scoreboard: accepted constants in order, rebuilt from observed beats.
  logic [15:0] exq[$];
  bit          pending;
  logic [7:0]  hi_seen;
  int          model_short;
  int          model_long;
  bit          held;
  logic [11:0] held_val;

  always @(posedge rst) begin
    exq.delete();
    pending     = 0;
    held        = 0;
    model_short = 0;
    model_long  = 0;
  end

  always @(negedge clk) begin
    logic [15:0] d;
    logic [15:0] rec;
    logic [7:0]  f;
    if (!rst) begin
      f = {instr7_4, instr3_0};
      if (held) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_beat", {20'd0, f, out_kind, out_last, 1'b0}, {20'd0, held_val});
      end
      held     = out_valid && !out_ready;
      held_val = {f, out_kind, out_last, 1'b0};
      if (out_valid && out_kind == KIND_HI) chk("hi_in_ready", {31'd0, in_ready}, 32'd0);
      if (in_valid && in_ready) exq.push_back(in_data);
      if (out_valid && out_ready) begin
        if (out_kind == KIND_SHORT) begin
          chk("short_no_pending", {31'd0, pending}, 32'd0);
          chk("short_last", {31'd0, out_last}, 32'd1);
          if (exq.size() == 0) chk("short_no_input", 32'd0, 32'd1);
          else begin
            d = exq.pop_front();
            rec = {{8{f[7]}}, f};
            chk("short_fit", {31'd0, ref_fits(d)}, 32'd1);
            chk("short_value", {16'd0, rec}, {16'd0, d});
            model_short++;
          end
        end else if (out_kind == KIND_HI) begin
          chk("hi_no_pending", {31'd0, pending}, 32'd0);
          chk("hi_last", {31'd0, out_last}, 32'd0);
          if (exq.size() == 0) chk("hi_no_input", 32'd0, 32'd1);
          else chk("hi_fit", {31'd0, ref_fits(exq[0])}, 32'd0);
          pending = 1;
          hi_seen = f;
        end else if (out_kind == KIND_LO) begin
          chk("lo_pending", {31'd0, pending}, 32'd1);
          chk("lo_last", {31'd0, out_last}, 32'd1);
          pending = 0;
          if (exq.size() == 0) chk("lo_no_input", 32'd0, 32'd1);
          else begin
            d = exq.pop_front();
            rec = {hi_seen, 8'd0} + {{8{f[7]}}, f};
            chk("long_value", {16'd0, rec}, {16'd0, d});
            model_long++;
          end
        end else begin
          chk("bad_kind", {30'd0, out_kind}, {30'd0, KIND_SHORT});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string name, input logic [1:0] k, input logic [7:0] f, input logic l);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_beat"}, {21'd0, instr7_4, instr3_0, out_kind, out_last},
        {21'd0, f, k, l});
  endtask

  function automatic logic [15:0] gen();
    logic [15:0] b[8];
    b[0] = 16'h007F; b[1] = 16'hFF80; b[2] = 16'h0080; b[3] = 16'hFF7F;
    b[4] = 16'h7FFF; b[5] = 16'h8000; b[6] = 16'hFFFF; b[7] = 16'h0000;
    case ($urandom_range(3))
      0: begin
        logic [7:0] s;
        s = 8'($urandom);
        return {{8{s[7]}}, s};
      end
      1: return b[$urandom_range(7)];
      default: return 16'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [15:0] d;
    bit          is_long;
    logic [7:0]  f0;
    logic [7:0]  f1;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int sent;
    int cyc;
    bit acc;

    tbl[0] = '{16'h007F, 1'b0, 8'h7F, 8'h00};
    tbl[1] = '{16'hFF80, 1'b0, 8'h80, 8'h00};
    tbl[2] = '{16'h0080, 1'b1, 8'h01, 8'h80};
    tbl[3] = '{16'h7FFF, 1'b1, 8'h80, 8'hFF};
    tbl[4] = '{16'h1234, 1'b1, 8'h12, 8'h34};
    tbl[5] = '{16'hFFFF, 1'b0, 8'hFF, 8'h00};
    tbl[6] = '{16'h8000, 1'b1, 8'h80, 8'h00};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #3;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_beat", {21'd0, instr7_4, instr3_0, out_kind, out_last}, 32'd0);
    chk("rst_cnts", {16'd0, short_cnt, long_cnt}, 32'd0);
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      step();
      in_valid = 1'b1; in_data = tbl[i].d;
      @(negedge clk);
      chk("tbl_idle_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      if (tbl[i].is_long) begin
        chk_beat("tbl_hi", KIND_HI, tbl[i].f0, 1'b0);
        chk("tbl_hi_ready", {31'd0, in_ready}, 32'd0);
        step();
        @(negedge clk);
        chk_beat("tbl_lo", KIND_LO, tbl[i].f1, 1'b1);
      end else begin
        chk_beat("tbl_short", KIND_SHORT, tbl[i].f0, 1'b1);
      end
      step();
      @(negedge clk);
      chk("tbl_drained", {31'd0, out_valid}, 32'd0);
    end
    chk("tbl_short_cnt", {24'd0, short_cnt}, 32'd3);
    chk("tbl_long_cnt", {24'd0, long_cnt}, 32'd4);

    // Back-to-back SHORT constants, one per cycle.
    step();
    in_valid = 1'b1; in_data = 16'h007F;
    step();
    in_data = 16'hFF80;
    @(negedge clk);
    chk_beat("b2b_0", KIND_SHORT, 8'h7F, 1'b1);
    chk("b2b_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk_beat("b2b_1", KIND_SHORT, 8'h80, 1'b1);
    step();
    @(negedge clk);
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);
    chk("b2b_short_cnt", {24'd0, short_cnt}, 32'd5);

    // Backpressure held on the HI beat.
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hABCD;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_beat("bp_hi", KIND_HI, 8'hAC, 1'b0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_beat("bp_hi_rel", KIND_HI, 8'hAC, 1'b0);
    step();
    @(negedge clk);
    chk_beat("bp_lo", KIND_LO, 8'hCD, 1'b1);
    step();
    @(negedge clk);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_long_cnt", {24'd0, long_cnt}, 32'd5);

    // Reset in the middle of the LO beat of 0x4000.
    step();
    in_valid = 1'b1; in_data = 16'h4000;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk_beat("rs_hi", KIND_HI, 8'h40, 1'b0);
    step();
    @(negedge clk);
    chk_beat("rs_lo", KIND_LO, 8'h00, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rs_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_async_beat", {21'd0, instr7_4, instr3_0, out_kind, out_last}, 32'd0);
    chk("rs_async_cnts", {16'd0, short_cnt, long_cnt}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rs_idle", {31'd0, out_valid}, 32'd0);
    step();
    in_valid = 1'b1; in_data = 16'h0005;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk_beat("rs_short", KIND_SHORT, 8'h05, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("rs_no_stray", {31'd0, out_valid}, 32'd0);
    end
    chk("rs_short_cnt", {24'd0, short_cnt}, 32'd1);
    chk("rs_long_cnt", {24'd0, long_cnt}, 32'd0);

    // Random traffic against the scoreboard.
    sent = 0; cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) sent++;
      out_ready = ($urandom_range(7) != 0);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(7) != 0) && (sent < 10000);
        in_data  = gen();
      end
    end
    in_valid = 1'b0;
    chk("rand_timeout", {31'd0, (sent >= 10000)}, 32'd1);
    out_ready = 1'b1;
    cyc = 0;
    while ((out_valid || exq.size() != 0) && cyc < 20) begin
      step();
      cyc++;
    end
    @(negedge clk);
    chk("rand_drained", {31'd0, out_valid}, 32'd0);
    chk("rand_queue_empty", exq.size(), 32'd0);
    chk("rand_no_pending", {31'd0, pending}, 32'd0);
    chk("rand_short_cnt", {24'd0, short_cnt}, model_short & 255);
    chk("rand_long_cnt", {24'd0, long_cnt}, model_long & 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
